seq_writeback_pc: RTL and testbench

- Write-back and PC-update stage of the SEQ Y86-64 processor. Sits directly downstream of the memory stage and consumes valM and dmem_error from it.
- Holds the architectural state:
  - 15-entry 64-bit register file, with two combinational read ports for decode;
  - program counter;
  - sticky status register;
  - retired-instruction counter.
- Commits one instruction per clock when step is high.

---
 rtl/seq_writeback_pc.sv | 76 +++++++
 tb/tb_seq_writeback_pc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_writeback_pc.sv
// seq_writeback_pc: SEQ Y86-64 write-back and PC-update stage holding the register file, pc, sticky status and retired count.
module seq_writeback_pc #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  output logic [63:0]      pc,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] R_NONE = 4'hF;
  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [2:0]       next_stat;
  logic             live, commit, we_e, we_m;
  always_comb begin
    next_stat = imem_error ? S_ADR : !instr_valid ? S_INS : dmem_error ? S_ADR :
                (icode == 4'h0) ? S_HLT : S_AOK;
    live = step && stat_q == S_AOK;
    commit = live && next_stat == S_AOK;
    we_e = commit && dstE != R_NONE && (icode != 4'h2 || cnd);
    we_m = commit && dstM != R_NONE;
    regs_d = regs_q;
    if (we_e) regs_d[dstE] = valE;
    // valM is written last so it wins when both ports target the same register
    if (we_m) regs_d[dstM] = valM;
    pc_d = !commit ? pc_q : (icode == 4'h8) ? valC : (icode == 4'h7) ? (cnd ? valC : valP) :
           (icode == 4'h9) ? valM : valP;
    stat_d = (live && next_stat != S_AOK) ? next_stat : stat_q;
    retired_d = retired_q + CNT_W'(commit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pc_q <= RESET_PC;
      stat_q <= S_AOK;
      retired_q <= '0;
    end else begin
      regs_q <= regs_d;
      pc_q <= pc_d;
      stat_q <= stat_d;
      retired_q <= retired_d;
    end
  end
  assign valA = (srcA == R_NONE) ? 64'h0 : regs_q[srcA];
  assign valB = (srcB == R_NONE) ? 64'h0 : regs_q[srcB];
  assign pc = pc_q;
  assign stat = stat_q;
  assign halted = stat_q != S_AOK;
  assign retired = retired_q;
endmodule

// File: tb/tb_seq_writeback_pc.sv
// tb_seq_writeback_pc: directed and random checks of seq_writeback_pc against a behavioural architectural-state model.
module tb_seq_writeback_pc;
  logic        clk = 0, reset = 0, step = 0, cnd = 0, instr_valid = 1, imem_error = 0, dmem_error = 0;
  logic [3:0]  icode = 4'h1, dstE = 4'hF, dstM = 4'hF, srcA = 4'hF, srcB = 4'hF;
  logic [63:0] valE = 0, valM = 0, valC = 0, valP = 0;
  logic [63:0] valA, valB, pc, valA4, valB4, pc4;
  logic [2:0]  stat, stat4;
  logic        halted, halted4;
  logic [31:0] retired;
  logic [3:0]  retired4;
  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [63:0] m_regs [15];
  logic [63:0] m_pc;
  logic [2:0]  m_stat, ns;
  int unsigned m_ret;

  seq_writeback_pc #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .step(step), .icode(icode), .cnd(cnd), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .dstE(dstE), .dstM(dstM), .valE(valE),
    .valM(valM), .valC(valC), .valP(valP), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .pc(pc), .stat(stat), .halted(halted), .retired(retired));

  seq_writeback_pc #(.RESET_PC(64'h0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .step(step), .icode(icode), .cnd(cnd), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .dstE(dstE), .dstM(dstM), .valE(valE),
    .valM(valM), .valC(valC), .valP(valP), .srcA(srcA), .srcB(srcB), .valA(valA4), .valB(valB4),
    .pc(pc4), .stat(stat4), .halted(halted4), .retired(retired4));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  // Architectural reference: one instruction's effect applied at each rising edge
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      m_pc = 64'h0;
      m_stat = 3'd1;
      m_ret = 0;
    end else if (step && m_stat == 3'd1) begin
      ns = imem_error ? 3'd3 : !instr_valid ? 3'd4 : dmem_error ? 3'd3 : icode == 4'h0 ? 3'd2 : 3'd1;
      if (ns != 3'd1) m_stat = ns;
      else begin
        if (dstE != 4'hF && (icode != 4'h2 || cnd)) m_regs[dstE] = valE;
        if (dstM != 4'hF) m_regs[dstM] = valM;
        case (icode)
          4'h8: m_pc = valC;
          4'h7: m_pc = cnd ? valC : valP;
          4'h9: m_pc = valM;
          default: m_pc = valP;
        endcase
        m_ret++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valA", valA, srcA == 4'hF ? 64'h0 : m_regs[srcA]);
      chk("valB", valB, srcB == 4'hF ? 64'h0 : m_regs[srcB]);
      chk("pc", pc, m_pc);
      chk("stat", {61'h0, stat}, {61'h0, m_stat});
      chk("halted", {63'h0, halted}, {63'h0, m_stat != 3'd1});
      chk("retired", {32'h0, retired}, {32'h0, m_ret});
      chk("retired4", {60'h0, retired4}, {60'h0, m_ret[3:0]});
      chk("pc4", pc4, m_pc);
    end
  end

  task automatic do_reset();
    reset = 1; step = 0;
    @(negedge clk); #1;
    reset = 0;
  endtask

  task automatic go(input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm,
                    input logic [63:0] ve, input logic [63:0] vm, input logic [63:0] vc,
                    input logic [63:0] vp, input logic c);
    icode = ic; dstE = de; dstM = dm; valE = ve; valM = vm; valC = vc; valP = vp; cnd = c; step = 1;
    @(negedge clk); #1;
    step = 0;
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    srcA = 4'h0;
    #1;
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", {61'h0, stat}, 64'd1);
    chk("rst_ret", {32'h0, retired}, 64'd0);
    chk("rst_reg0", valA, 64'h0);
    go(4'h3, 4'h0, 4'hF, 64'h1234, 0, 0, 64'd10, 0);
    chk("irmov_reg0", valA, 64'h1234);
    chk("irmov_pc", pc, 64'd10);
    chk("irmov_ret", {32'h0, retired}, 64'd1);
    chk("model_reg0", m_regs[0], 64'h1234);
    srcB = 4'h3;
    go(4'h2, 4'h3, 4'hF, 64'h5, 0, 0, 64'h20, 0);
    chk("cmov0_reg3", valB, 64'h0);
    chk("cmov0_pc", pc, 64'h20);
    go(4'h2, 4'h3, 4'hF, 64'h5, 0, 0, 64'h30, 1);
    chk("cmov1_reg3", valB, 64'h5);
    srcA = 4'h4;
    go(4'hB, 4'h4, 4'h4, 64'h108, 64'hAA, 0, 64'h32, 0);
    chk("popq_rsp", valA, 64'hAA);
    chk("model_rsp", m_regs[4], 64'hAA);
    go(4'h7, 4'hF, 4'hF, 0, 0, 64'h40, 64'h20, 1);
    chk("jxx_taken", pc, 64'h40);
    go(4'h7, 4'hF, 4'hF, 0, 0, 64'h40, 64'h20, 0);
    chk("jxx_fall", pc, 64'h20);
    go(4'h8, 4'h4, 4'hF, 64'h100, 0, 64'h100, 64'h29, 0);
    chk("call_pc", pc, 64'h100);
    go(4'h9, 4'h4, 4'hF, 64'h108, 64'h58, 0, 64'h101, 0);
    chk("ret_pc", pc, 64'h58);
    go(4'h0, 4'hF, 4'hF, 0, 0, 0, 64'h59, 0);
    chk("halt_stat", {61'h0, stat}, 64'd2);
    chk("halt_flag", {63'h0, halted}, 64'd1);
    chk("halt_pc", pc, 64'h58);
    chk("halt_ret", {32'h0, retired}, 64'd8);
    do_reset();
    srcA = 4'h2;
    dmem_error = 1;
    go(4'h5, 4'hF, 4'h2, 0, 64'h77, 64'h8, 64'h10, 0);
    dmem_error = 0;
    chk("dmem_stat", {61'h0, stat}, 64'd3);
    chk("dmem_halted", {63'h0, halted}, 64'd1);
    chk("dmem_pc", pc, 64'h0);
    chk("dmem_reg2", valA, 64'h0);
    go(4'h3, 4'h2, 4'hF, 64'h99, 0, 0, 64'h10, 0);
    chk("sticky_reg2", valA, 64'h0);
    chk("sticky_pc", pc, 64'h0);
    chk("sticky_ret", {32'h0, retired}, 64'd0);
    do_reset();
    chk("rst_halt_stat", {61'h0, stat}, 64'd1);
    chk("rst_halt_pc", pc, 64'h0);
    imem_error = 1; instr_valid = 0;
    go(4'h3, 4'h1, 4'hF, 64'h1, 0, 0, 64'h10, 0);
    imem_error = 0; instr_valid = 1;
    chk("imem_prio", {61'h0, stat}, 64'd3);
    do_reset();
    instr_valid = 0;
    go(4'h3, 4'h1, 4'hF, 64'h1, 0, 0, 64'h10, 0);
    instr_valid = 1;
    chk("ins_stat", {61'h0, stat}, 64'd4);
    do_reset();
    go(4'h6, 4'h1, 4'hF, 64'h1, 0, 0, 64'h2, 0);
    go(4'h6, 4'h1, 4'hF, 64'h2, 0, 0, 64'h4, 0);
    icode = 4'h3; dstE = 4'h1;
    repeat (5) @(negedge clk);
    #1;
    chk("idle_ret", {32'h0, retired}, 64'd2);
    do_reset();
    for (int i = 0; i < 16; i++) go(4'h6, 4'h1, 4'hF, 64'(i), 0, 0, 64'(i + 1), 0);
    chk("wrap_ret4", {60'h0, retired4}, 64'd0);
    chk("wrap_ret32", {32'h0, retired}, 64'd16);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      step = ($urandom_range(0, 3) != 0);
      icode = 4'($urandom_range(0, 15));
      if (icode == 4'h0 && $urandom_range(0, 3) != 0) icode = 4'h6;
      cnd = 1'($urandom);
      instr_valid = ($urandom_range(0, 39) != 0);
      imem_error = ($urandom_range(0, 49) == 0);
      dmem_error = ($urandom_range(0, 49) == 0);
      dstE = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dstM = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      valE = {$urandom, $urandom};
      valM = {$urandom, $urandom};
      valC = {$urandom, $urandom};
      valP = {$urandom, $urandom};
      @(negedge clk); #1;
    end
    reset = 0; step = 0;
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
